// File: rtl/pin_harness_pkg.sv
// Shared definitions for the pin shift harness.
//   harness_state_e : frame sequencing states
//   SETTLE_W        : bit width of the SETTLE parameter (0..255)
//   cnt_width()     : width of the shared cycle/bit counter
package pin_harness_pkg;

    typedef enum logic [1:0] {
        SHIFT_IN    = 2'd0,
        SETTLE_WAIT = 2'd1,
        CAPTURE     = 2'd2,
        SHIFT_OUT   = 2'd3
    } harness_state_e;

    localparam int unsigned SETTLE_W = 8;

    // $clog2(max(a, b, c) + 1), never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/harness_shreg.sv
// Shift register with a serial input, a parallel load and a parallel view.
//   clk, rst  : clock, asynchronous active-high reset (clears the register)
//   shift_en  : shift left by one, ser_in entering at the LSB
//   load_en   : load par_in (has priority over shift_en)
//   ser_in    : serial input bit
//   par_in    : parallel load value
//   q         : current register contents (MSB is the serial output end)
module harness_shreg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         shift_en,
    input  logic         load_en,
    input  logic         ser_in,
    input  logic [W-1:0] par_in,
    output logic [W-1:0] q
);

    logic [W-1:0] q_q;
    logic [W-1:0] q_d;

    always_comb begin
        q_d = q_q;
        if (load_en) begin
            q_d = par_in;
        end else if (shift_en) begin
            // Whole-vector shift keeps W=1 legal (result is just ser_in).
            q_d = (q_q << 1) | W'(ser_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/pin_shift_harness.sv
// Serial-to-parallel stimulus / parallel-to-serial capture harness around an
// externally instantiated device under test.
//   clk, rst  : clock, asynchronous active-high reset
//   di        : serial stimulus bit, sampled when di_valid=1 and busy=0
//   di_valid  : stimulus bit qualifier
//   din       : registered parallel stimulus (DIN_N bits) to the device
//   dout      : parallel response (DOUT_N bits) from the device
//   do_bit    : serial response bit, MSB first ("do" is a reserved word)
//   do_valid  : high exactly while do_bit carries a response bit
//   busy      : high in every state except SHIFT_IN
module pin_shift_harness
    import pin_harness_pkg::*;
#(
    parameter int unsigned          DIN_N  = 8,
    parameter int unsigned          DOUT_N = 8,
    parameter logic [SETTLE_W-1:0]  SETTLE = 8'd2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              di,
    input  logic              di_valid,
    output logic [DIN_N-1:0]  din,
    input  logic [DOUT_N-1:0] dout,
    output logic              do_bit,
    output logic              do_valid,
    output logic              busy
);

    localparam int unsigned SETTLE_CYC = SETTLE;
    localparam int unsigned CNT_W      = cnt_width(DIN_N, DOUT_N, SETTLE_CYC);

    localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(DIN_N - 1);
    localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(DOUT_N - 1);
    localparam logic [CNT_W-1:0] SET_LAST = CNT_W'((SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0);

    harness_state_e    state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DIN_N-1:0]  din_q, din_d;
    logic              do_q, do_d;
    logic              do_valid_q, do_valid_d;

    logic [DIN_N-1:0]  in_q;
    logic [DIN_N-1:0]  in_next;
    logic [DOUT_N-1:0] out_q;
    logic              out_msb;
    logic              in_shift;
    logic              out_shift;
    logic              out_load;

    harness_shreg #(.W(DIN_N)) u_stim_shreg (
        .clk      (clk),
        .rst      (rst),
        .shift_en (in_shift),
        .load_en  (1'b0),
        .ser_in   (di),
        .par_in   ('0),
        .q        (in_q)
    );

    harness_shreg #(.W(DOUT_N)) u_resp_shreg (
        .clk      (clk),
        .rst      (rst),
        .shift_en (out_shift),
        .load_en  (out_load),
        .ser_in   (1'b0),
        .par_in   (dout),
        .q        (out_q)
    );

    // Value the stimulus register takes on this edge; lets din load the
    // complete frame on the same edge as its final bit.
    assign in_next = (in_q << 1) | DIN_N'(di);
    assign out_msb = |(out_q >> (DOUT_N - 1));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        din_d      = din_q;
        do_d       = 1'b0;
        do_valid_d = 1'b0;
        in_shift   = 1'b0;
        out_shift  = 1'b0;
        out_load   = 1'b0;

        unique case (state_q)
            SHIFT_IN: begin
                if (di_valid) begin
                    in_shift = 1'b1;
                    if (cnt_q == IN_LAST) begin
                        din_d   = in_next;
                        cnt_d   = '0;
                        state_d = (SETTLE_CYC > 0) ? SETTLE_WAIT : CAPTURE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            SETTLE_WAIT: begin
                if (cnt_q == SET_LAST) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            CAPTURE: begin
                out_load = 1'b1;
                state_d  = SHIFT_OUT;
            end
            SHIFT_OUT: begin
                // do/do_valid are registered, so each bit appears one cycle
                // after its SHIFT_OUT cycle and the last one overlaps SHIFT_IN.
                out_shift  = 1'b1;
                do_d       = out_msb;
                do_valid_d = 1'b1;
                if (cnt_q == OUT_LAST) begin
                    cnt_d   = '0;
                    state_d = SHIFT_IN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = SHIFT_IN;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= SHIFT_IN;
            cnt_q      <= '0;
            din_q      <= '0;
            do_q       <= 1'b0;
            do_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            din_q      <= din_d;
            do_q       <= do_d;
            do_valid_q <= do_valid_d;
        end
    end

    assign din      = din_q;
    assign do_bit   = do_q;
    assign do_valid = do_valid_q;
    assign busy     = (state_q != SHIFT_IN);

endmodule

// File: tb/tb_pin_shift_harness.sv
// Directed bench for pin_shift_harness: three configurations share di/di_valid,
// the ones not under test are held in reset, and their outputs are muxed by sel.
module tb_pin_shift_harness;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b1, rst_b = 1'b1, rst_c = 1'b1;
    logic di = 1'b0, dv = 1'b0;

    logic [7:0]  dout_a = 8'hA5;
    logic [7:0]  dout_b = 8'h01;
    logic [11:0] dout_c = 12'h800;

    logic [7:0] din_a, din_b;
    logic [2:0] din_c;
    logic do_a, do_b, do_c, val_a, val_b, val_c, busy_a, busy_b, busy_c;

    pin_shift_harness #(.DIN_N(8), .DOUT_N(8), .SETTLE(8'd2)) u_a (
        .clk(clk), .rst(rst_a), .di(di), .di_valid(dv), .din(din_a),
        .dout(dout_a), .do_bit(do_a), .do_valid(val_a), .busy(busy_a));

    pin_shift_harness #(.DIN_N(8), .DOUT_N(8), .SETTLE(8'd0)) u_b (
        .clk(clk), .rst(rst_b), .di(di), .di_valid(dv), .din(din_b),
        .dout(dout_b), .do_bit(do_b), .do_valid(val_b), .busy(busy_b));

    pin_shift_harness #(.DIN_N(3), .DOUT_N(12), .SETTLE(8'd2)) u_c (
        .clk(clk), .rst(rst_c), .di(di), .di_valid(dv), .din(din_c),
        .dout(dout_c), .do_bit(do_c), .do_valid(val_c), .busy(busy_c));

    int unsigned sel = 0;
    logic [31:0] o_din;
    logic        o_do, o_val, o_busy;

    always_comb begin
        o_din = '0; o_do = 1'b0; o_val = 1'b0; o_busy = 1'b0;
        case (sel)
            0: begin o_din = 32'(din_a); o_do = do_a; o_val = val_a; o_busy = busy_a; end
            1: begin o_din = 32'(din_b); o_do = do_b; o_val = val_b; o_busy = busy_b; end
            default: begin o_din = 32'(din_c); o_do = do_c; o_val = val_c; o_busy = busy_c; end
        endcase
    end

    int n_total = 0;
    int n_bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends n_in bits of 'bits' MSB first and follows the frame to completion.
    task automatic run_frame(input string tag, input int unsigned n_in,
                             input int unsigned n_out, input int unsigned settle,
                             input logic [31:0] bits, input logic [31:0] prev_din,
                             input logic [31:0] out_exp, input bit gap, input bit keep_dv);
        int unsigned lat;
        for (int i = 0; i < int'(n_in); i++) begin
            if (gap && i == int'(n_in / 2)) begin
                dv = 1'b0; di = 1'b1;
                repeat (3) tick();
                chk({tag, "_gap_busy"}, 32'(o_busy), 32'd0);
            end
            di = bits[n_in - 1 - i];
            dv = 1'b1;
            if (i == int'(n_in) - 1) begin
                chk({tag, "_pre_busy"}, 32'(o_busy), 32'd0);
                chk({tag, "_din_hold"}, o_din, prev_din);
            end
            tick();
        end
        chk({tag, "_din"}, o_din, bits);
        chk({tag, "_busy"}, 32'(o_busy), 32'd1);
        if (!keep_dv) dv = 1'b0;

        lat = 0;
        while (o_val !== 1'b1 && lat < 64) begin
            di = ~di;
            tick();
            lat++;
        end
        chk({tag, "_latency"}, lat, settle + 2);

        for (int j = 0; j < int'(n_out); j++) begin
            chk({tag, "_do"}, 32'(o_do), 32'(out_exp[n_out - 1 - j]));
            chk({tag, "_do_valid"}, 32'(o_val), 32'd1);
            if (j < int'(n_out) - 1) begin
                di = ~di;
                tick();
            end
        end
        chk({tag, "_busy_end"}, 32'(o_busy), 32'd0);
        dv = 1'b0;
        tick();
        chk({tag, "_valid_fall"}, 32'(o_val), 32'd0);
        chk({tag, "_do_idle"}, 32'(o_do), 32'd0);
        chk({tag, "_din_keep"}, o_din, bits);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_din", o_din, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_valid", 32'(o_val), 32'd0);
        chk("rst_do", 32'(o_do), 32'd0);
        rst_a = 1'b0;

        // Config A: DIN_N=8, DOUT_N=8, SETTLE=2, dout=A5
        run_frame("a_b2", 8, 8, 2, 32'hB2, 32'h00, 32'hA5, 1'b0, 1'b0);
        run_frame("a_5c", 8, 8, 2, 32'h5C, 32'hB2, 32'hA5, 1'b1, 1'b1);
        run_frame("a_0f", 8, 8, 2, 32'h0F, 32'h5C, 32'hA5, 1'b0, 1'b0);

        // Reset part-way through a frame
        for (int i = 0; i < 5; i++) begin
            di = 1'b1; dv = 1'b1;
            tick();
        end
        dv = 1'b0;
        #2 rst_a = 1'b1;
        #1;
        chk("mid_rst_din", o_din, 32'd0);
        chk("mid_rst_busy", 32'(o_busy), 32'd0);
        chk("mid_rst_valid", 32'(o_val), 32'd0);
        chk("mid_rst_do", 32'(o_do), 32'd0);
        tick();
        rst_a = 1'b0;
        run_frame("a_ff", 8, 8, 2, 32'hFF, 32'h00, 32'hA5, 1'b0, 1'b0);

        // Config B: SETTLE=0, dout=01
        rst_a = 1'b1;
        sel = 1;
        tick();
        rst_b = 1'b0;
        run_frame("b_3c", 8, 8, 0, 32'h3C, 32'h00, 32'h01, 1'b0, 1'b0);

        // Config C: DIN_N=3, DOUT_N=12, dout=800
        rst_b = 1'b1;
        sel = 2;
        tick();
        rst_c = 1'b0;
        run_frame("c_5", 3, 12, 2, 32'h5, 32'h0, 32'h800, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pin_shift_harness.md
PIN_SHIFT_HARNESS -- requirements
Module: pin_shift_harness

Interface
REQ-001 Parameter DIN_N, default 8, width of parallel stimulus bus; SHALL be >= 1.
REQ-002 Parameter DOUT_N, default 8, width of parallel capture bus; SHALL be >= 1.
REQ-003 Parameter SETTLE, default 2, number of idle cycles between stimulus update and capture; SHALL be 0..255.
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 di  input  1  serial stimulus bit.
REQ-007 di_valid  input  1  di SHALL be sampled only when high and busy low.
REQ-008 din  output  DIN_N  registered parallel stimulus driving the device under test.
REQ-009 dout  input  DOUT_N  parallel response from the device under test.
REQ-010 do  output  1  serial response bit, MSB first.
REQ-011 do_valid  output  1  high exactly while do carries a response bit.
REQ-012 busy  output  1  high in every state except SHIFT_IN.

Function
REQ-013 FSM states SHIFT_IN, SETTLE_WAIT, CAPTURE, SHIFT_OUT; transitions occur only on clk rising edge.
REQ-014 SHIFT_IN: each accepted bit SHALL shift into an internal DIN_N-bit register LSB end (first bit ends at MSB); bit counter increments.
REQ-015 On acceptance of the DIN_N-th bit, din SHALL be loaded with the full shift value on that same edge, and the counter SHALL clear.
REQ-016 Then if SETTLE>0 enter SETTLE_WAIT for exactly SETTLE cycles; if SETTLE=0 enter CAPTURE directly.
REQ-017 CAPTURE: one cycle; dout SHALL be sampled into the DOUT_N-bit output shift register at the end of this cycle; next state SHIFT_OUT.
REQ-018 SHIFT_OUT: DOUT_N consecutive cycles, do = output-register MSB, do_valid=1, register shifts left each cycle filling 0.
REQ-019 After the DOUT_N-th output bit, return to SHIFT_IN; do_valid SHALL fall the following cycle.
REQ-020 Latency from the last input bit's edge to first do_valid=1 SHALL be SETTLE+2 cycles.
REQ-021 di_valid while busy=1 SHALL be ignored with no state change, including the final SHIFT_OUT cycle.
REQ-022 di_valid gaps in SHIFT_IN SHALL hold partial state indefinitely; din SHALL hold its last loaded value until the next full frame.
REQ-023 do SHALL be 0 whenever do_valid=0.
REQ-024 Counters SHALL be sized $clog2 of max(DIN_N, DOUT_N, SETTLE)+1, minimum 1 bit; no wrap-around beyond terminal counts.

Reset
REQ-025 rst high SHALL immediately force state SHIFT_IN, all counters 0, din=0, both shift registers 0, do=0, do_valid=0, busy=0.
REQ-026 rst asserted mid-frame in any state SHALL discard the partial frame; after release the next accepted bit is bit 0 of a new frame.
REQ-027 First di_valid sample SHALL occur on the first clk edge after rst deasserts.

Structure
REQ-028 FSM state enum and SETTLE width constant SHALL live in shared package pin_harness_pkg.
REQ-029 One sub-module, harness_shreg (parametrised width, serial-in/parallel-load/serial-out), SHALL be instantiated twice, once for stimulus and once for response.
REQ-030 The block SHALL contain no device primitive; the DUT is instantiated by the enclosing top.

Verification
REQ-031 DIN_N=8, SETTLE=2: shift 1,0,1,1,0,0,1,0 contiguously -> din=8'hB2 on 8th edge, busy=1 same edge.
REQ-032 dout tied to 8'hA5 -> do_valid high 4 cycles after last di edge, do sequence 1,0,1,0,0,1,0,1, then busy=0.
REQ-033 SETTLE=0, dout=8'h01 -> first do_valid 2 cycles after last input bit, final bit do=1.
REQ-034 di_valid held high through whole frame -> exactly 8 bits accepted; bits during busy ignored, din unchanged until next frame.
REQ-035 rst pulsed after 5 input bits -> all outputs 0; subsequent 8-bit frame 8'hFF yields din=8'hFF.
REQ-036 DIN_N=3, DOUT_N=12, dout=12'h800 -> 12 do_valid cycles, only first do=1.
